prog_loader: RTL and testbench

- Byte-stream boot loader. Drives the CPU program-loading port (prog_load_en / prog_addr / prog_data) into instruction memory.
- Receives framed bytes from a host link (UART receiver or testbench) on a valid/ready interface and assembles little-endian 32-bit instructions.
- Holds the CPU in reset until a frame completes.
- Sits beside the CPU at SoC top level. Its outputs connect one-to-one to the CPU's load inputs, and cpu_hold is ORed into the CPU reset.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader_word_asm.sv | 50 +++++
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg: shared state encoding and frame constants | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prog_loader_pkg;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
  localparam int         LEN_W         = 16;
  localparam int         WORD_BYTES    = 4;
  localparam int         IDX_W         = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    CHECK  = 3'd6
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if: host byte link plus instruction-memory load port | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        prog_load_en;
  logic [63:0] prog_addr;
  logic [31:0] prog_data;

  // master: host side that sources bytes and observes the load port
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, prog_load_en, prog_addr, prog_data
  );

  // slave: the loader itself
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, prog_load_en, prog_addr, prog_data
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader_word_asm.sv
// ---------------------------------------------------------------------------
// prog_loader_word_asm: little-endian byte-to-word assembler | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader_word_asm
  import prog_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic [8*WORD_BYTES-1:0]   word_o,
  output logic                      word_done_o
);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_valid_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 1'b1;
    end
  end

  // word_o already includes the byte arriving this cycle so the top can
  // register it alongside the strobe on the same edge
  assign word_o      = word_d;
  assign word_done_o = byte_valid_i && (idx_q == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader: framed byte-stream boot loader; PROG_LOADER_CHECKSUM_EN adds
// a trailing XOR checksum byte | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h0,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  input  logic          restart,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error,
  output logic [15:0]   words_loaded
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t                  state_q;
  logic [7:0]              len_lo_q;
  logic [LEN_W-1:0]        len_q;
  logic [15:0]             words_q;
  logic [TO_W-1:0]         to_q;
  logic                    prog_en_q;
  logic [63:0]             addr_q;
  logic [31:0]             data_q;

  logic                    xfer;
  logic                    in_frame;
  logic                    is_magic;
  logic                    last_word;
  logic                    word_done;
  logic [31:0]             word;
  logic [LEN_W-1:0]        len_rx;

  assign xfer      = bus.rx_valid && bus.rx_ready;
  assign is_magic  = (bus.rx_data == MAGIC);
  assign len_rx    = {bus.rx_data, len_lo_q};
  assign last_word = ((words_q + 16'd1) == len_q);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHECK);
`else
  assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA);
`endif

  prog_loader_word_asm u_word_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (xfer && (state_q == IDLE) && is_magic),
    .byte_valid_i (xfer && (state_q == DATA)),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      words_q   <= '0;
      to_q      <= '0;
      prog_en_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      prog_en_q <= 1'b0;

      if (in_frame) begin
        to_q <= xfer ? '0 : to_q + 1'b1;
      end

      if (word_done) begin
        prog_en_q <= 1'b1;
        data_q    <= word;
        addr_q    <= BASE_ADDR + {46'b0, words_q, 2'b00};
        words_q   <= words_q + 16'd1;
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      if (xfer && ((state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA))) begin
        chk_q <= chk_q ^ bus.rx_data;
      end
`endif

      case (state_q)
        IDLE: begin
          if (xfer && is_magic) begin
            state_q <= LEN_LO;
            words_q <= '0;
            to_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo_q <= bus.rx_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q <= len_rx;
            if (len_rx > MAX_LEN) begin
              state_q <= ERROR;
            end else if (len_rx == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q <= DONE;
`endif
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q <= CHECK;
`else
            state_q <= DONE;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            state_q <= (bus.rx_data == chk_q) ? DONE : ERROR;
          end
        end
`endif
        DONE, ERROR: begin
          if (restart) begin
            state_q <= IDLE;
            words_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // the idle cycle that would bring the counter to the limit aborts the frame
      if (in_frame && !xfer && (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
        state_q <= ERROR;
      end
    end
  end

  assign bus.rx_ready     = (state_q != DONE) && (state_q != ERROR);
  assign bus.prog_load_en = prog_en_q;
  assign bus.prog_addr    = addr_q;
  assign bus.prog_data    = data_q;
  assign cpu_hold         = (state_q != DONE);
  assign load_done        = (state_q == DONE);
  assign load_error       = (state_q == ERROR);
  assign words_loaded     = words_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader: directed self-checking bench for prog_loader | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        cpu_hold, load_done, load_error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;

  int          strobe_cnt = 0;
  logic [63:0] s_addr[$];
  logic [31:0] s_data[$];

  prog_loader_if bus ();

  prog_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (1024),
    .TIMEOUT_CYCLES (16),
    .MAGIC          (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .restart      (restart),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.prog_load_en === 1'b1) begin
      strobe_cnt++;
      s_addr.push_back(bus.prog_addr);
      s_data.push_back(bus.prog_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    strobe_cnt = 0;
    s_addr.delete();
    s_data.delete();
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1)      begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
    checks++; if (bus.prog_load_en !== 1'b0)  begin failures++; $display("FAIL reset_load_en got=%b exp=0", bus.prog_load_en); end
    checks++; if (bus.prog_addr !== 64'h0)    begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.prog_addr); end
    checks++; if (bus.prog_data !== 32'h0)    begin failures++; $display("FAIL reset_data got=%h exp=0", bus.prog_data); end
    checks++; if (cpu_hold !== 1'b1)          begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0)         begin failures++; $display("FAIL reset_done got=%b exp=0", load_done); end
    checks++; if (load_error !== 1'b0)        begin failures++; $display("FAIL reset_error got=%b exp=0", load_error); end
    checks++; if (words_loaded !== 16'd0)     begin failures++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
  endtask

  // Two-word frame streamed back to back; checks strobe timing per word.
  // Checksum: 02^00^13^00^10^00^93^00^20^00 = 0xB2
  task automatic test_good_frame();
    logic [7:0] hdr[$] = '{8'hA5, 8'h02, 8'h00};
    logic [7:0] w0[$]  = '{8'h13, 8'h00, 8'h10, 8'h00};
    logic [7:0] w1[$]  = '{8'h93, 8'h00, 8'h20, 8'h00};
    clear_log();
    foreach (hdr[i]) send_byte(hdr[i]);
    foreach (w0[i]) send_byte(w0[i]);
    @(negedge clk);
    checks++; if (bus.prog_load_en !== 1'b1 || bus.prog_data !== 32'h0010_0013 || bus.prog_addr !== BASE)
      begin failures++; $display("FAIL good_strobe0 got en=%b addr=%h data=%h exp en=1 addr=%h data=00100013", bus.prog_load_en, bus.prog_addr, bus.prog_data, BASE); end
    checks++; if (words_loaded !== 16'd1) begin failures++; $display("FAIL good_words_at_strobe0 got=%0d exp=1", words_loaded); end
    foreach (w1[i]) send_byte(w1[i]);
    @(negedge clk);
    checks++; if (bus.prog_load_en !== 1'b1 || bus.prog_data !== 32'h0020_0093 || bus.prog_addr !== BASE + 64'd4)
      begin failures++; $display("FAIL good_strobe1 got en=%b addr=%h data=%h exp en=1 addr=%h data=00200093", bus.prog_load_en, bus.prog_addr, bus.prog_data, BASE + 64'd4); end
`ifdef PROG_LOADER_CHECKSUM_EN
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL good_done_before_chk got=%b exp=0", load_done); end
    send_byte(8'hB2);
`endif
    @(negedge clk);
    checks++; if (strobe_cnt !== 2) begin failures++; $display("FAIL good_strobe_count got=%0d exp=2", strobe_cnt); end
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_error !== 1'b0)
      begin failures++; $display("FAIL good_status got done=%b hold=%b err=%b exp done=1 hold=0 err=0", load_done, cpu_hold, load_error); end
    checks++; if (words_loaded !== 16'd2) begin failures++; $display("FAIL good_words got=%0d exp=2", words_loaded); end
    checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL good_rx_ready_done got=%b exp=0", bus.rx_ready); end
    checks++; if (bus.prog_load_en !== 1'b0 || bus.prog_data !== 32'h0020_0093 || bus.prog_addr !== BASE + 64'd4)
      begin failures++; $display("FAIL good_hold_values got en=%b addr=%h data=%h", bus.prog_load_en, bus.prog_addr, bus.prog_data); end
    repeat (3) @(negedge clk);
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL good_done_held got done=%b hold=%b", load_done, cpu_hold); end
  endtask

  task automatic test_restart();
    pulse_restart();
    @(negedge clk);
    checks++; if (load_done !== 1'b0 || load_error !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 16'd0 || bus.rx_ready !== 1'b1)
      begin failures++; $display("FAIL restart_state got done=%b err=%b hold=%b words=%0d rdy=%b", load_done, load_error, cpu_hold, words_loaded, bus.rx_ready); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                         8'h93, 8'h00, 8'h20, 8'h00, 8'hB3};
    clear_log();
    foreach (f[i]) send_byte(f[i]);
    @(negedge clk);
    checks++; if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0)
      begin failures++; $display("FAIL badchk_status got err=%b hold=%b done=%b exp err=1 hold=1 done=0", load_error, cpu_hold, load_done); end
    checks++; if (strobe_cnt !== 2 || words_loaded !== 16'd2)
      begin failures++; $display("FAIL badchk_words got strobes=%0d words=%0d exp 2/2", strobe_cnt, words_loaded); end
  endtask
`endif

  // Garbage before MAGIC; checksum 01^00^78^56^34^12 = 0x09
  task automatic test_garbage();
    logic [7:0] f[$] = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00,
                         8'h78, 8'h56, 8'h34, 8'h12};
    clear_log();
    foreach (f[i]) send_byte(f[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h09);
`endif
    repeat (2) @(negedge clk);
    checks++; if (strobe_cnt !== 1) begin failures++; $display("FAIL garbage_strobe_count got=%0d exp=1", strobe_cnt); end
    checks++; if (strobe_cnt >= 1 && (s_addr[0] !== BASE || s_data[0] !== 32'h1234_5678))
      begin failures++; $display("FAIL garbage_word got addr=%h data=%h exp addr=%h data=12345678", s_addr[0], s_data[0], BASE); end
    checks++; if (load_done !== 1'b1 || words_loaded !== 16'd1)
      begin failures++; $display("FAIL garbage_done got done=%b words=%0d exp 1/1", load_done, words_loaded); end
  endtask

  task automatic test_len_overflow();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    @(negedge clk);
    checks++; if (load_error !== 1'b1 || cpu_hold !== 1'b1)
      begin failures++; $display("FAIL overflow_error got err=%b hold=%b exp 1/1", load_error, cpu_hold); end
    send_byte(8'h11);
    @(negedge clk);
    checks++; if (strobe_cnt !== 0 || words_loaded !== 16'd0)
      begin failures++; $display("FAIL overflow_no_write got strobes=%0d words=%0d exp 0/0", strobe_cnt, words_loaded); end
  endtask

  task automatic test_max_len_accepted();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    @(negedge clk);
    checks++; if (load_error !== 1'b0 || bus.rx_ready !== 1'b1)
      begin failures++; $display("FAIL maxlen_accepted got err=%b rdy=%b exp 0/1", load_error, bus.rx_ready); end
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL timeout_early got err=%b exp=0 after 15 idle", load_error); end
    @(negedge clk);
    checks++; if (load_error !== 1'b1 || cpu_hold !== 1'b1)
      begin failures++; $display("FAIL timeout_fire got err=%b hold=%b exp 1/1 after 16 idle", load_error, cpu_hold); end
    checks++; if (strobe_cnt !== 0) begin failures++; $display("FAIL timeout_no_strobe got=%0d exp=0", strobe_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f[$] = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    foreach (f[i]) send_byte(f[i]);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.prog_load_en !== 1'b1 || bus.prog_data !== 32'hDDCC_BBAA)
      begin failures++; $display("FAIL midreset_strobe got en=%b data=%h exp en=1 data=ddccbbaa", bus.prog_load_en, bus.prog_data); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.prog_load_en !== 1'b0 || bus.prog_addr !== 64'h0 || bus.prog_data !== 32'h0)
      begin failures++; $display("FAIL midreset_port got en=%b addr=%h data=%h exp 0/0/0", bus.prog_load_en, bus.prog_addr, bus.prog_data); end
    checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || words_loaded !== 16'd0 || bus.rx_ready !== 1'b1)
      begin failures++; $display("FAIL midreset_status got hold=%b done=%b err=%b words=%0d rdy=%b", cpu_hold, load_done, load_error, words_loaded, bus.rx_ready); end
    repeat (3) @(negedge clk);
    checks++; if (strobe_cnt !== 1) begin failures++; $display("FAIL midreset_strobe_count got=%0d exp=1", strobe_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_restart();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_checksum();
    test_restart();
`endif
    test_garbage();
    test_restart();
    test_len_overflow();
    test_restart();
    test_max_len_accepted();
    test_reset();
    test_timeout();
    test_restart();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
